hazard_scoreboard: RTL and testbench

Decode-side hazard controller for the RV32I five-stage pipeline. Consumes the fields the decode stage places into the ID/EX register (source/destination register indices, load flag) and the writeback retire stream. It keeps a pending-load scoreboard and sequences taken-branch flushes, driving the stall, bubble and flush controls that the IF/ID and ID/EX pipeline registers obey.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_scoreboard_load_scoreboard.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 92 +++++++++
 tb/tb_hazard_scoreboard.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: register-file geometry, flush FSM states
// and the all-zero control word injected as a bubble.
package rv32i_pkg;

    localparam int NREG   = 32;
    localparam int RIDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    typedef struct packed {
        logic [1:0] wb;
        logic [1:0] mem;
        logic [3:0] exe;
    } crt_t;

    localparam crt_t CRT_NOP = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback hazard bus: ID/EX fields and retire stream in,
// pipeline-register controls and scoreboard view out.
interface hazard_scoreboard_if #(
    parameter int NREG   = 32,
    parameter int RIDX_W = 5
);
    logic              id_valid;
    logic [RIDX_W-1:0] id_rs1;
    logic [RIDX_W-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [RIDX_W-1:0] id_rd;
    logic              id_is_load;
    logic              ex_branch_taken;
    logic              wb_valid;
    logic [RIDX_W-1:0] wb_rd;
    logic              stall_if;
    logic              bubble_ex;
    logic              flush_id;
    logic              issue;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_is_load, ex_branch_taken, wb_valid, wb_rd,
        input  stall_if, bubble_ex, flush_id, issue, busy_vec
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_is_load, ex_branch_taken, wb_valid, wb_rd,
        output stall_if, bubble_ex, flush_id, issue, busy_vec
    );
endinterface

// File: rtl/hazard_scoreboard_load_scoreboard.sv
// Pending-load scoreboard: one busy bit per architectural register, with
// writeback-bypassed lookups for the two ID source operands.
module load_scoreboard #(
    parameter int NREG   = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_en,
    input  logic [RIDX_W-1:0] i_set_idx,
    input  logic              i_clr_en,
    input  logic [RIDX_W-1:0] i_clr_idx,
    input  logic [RIDX_W-1:0] i_rs1,
    input  logic [RIDX_W-1:0] i_rs2,
    output logic [NREG-1:0]   o_busy,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy
);
    import rv32i_pkg::*;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_eff_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Register file is write-first, so a same-cycle writeback already resolves the hazard.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
        if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
        w_eff_busy    = r_busy & ~w_clr_mask;
        w_busy_nxt    = w_eff_busy | w_set_mask;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_nxt;
    end

    assign o_busy     = r_busy;
    assign o_rs1_busy = w_eff_busy[i_rs1];
    assign o_rs2_busy = w_eff_busy[i_rs2];

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard controller: load-use stalls from the scoreboard and a
// fixed-length flush after every taken branch.
module hazard_scoreboard #(
    parameter int NREG     = rv32i_pkg::NREG,
    parameter int RIDX_W   = rv32i_pkg::RIDX_W,
    parameter int BR_FLUSH = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    import rv32i_pkg::*;

    localparam logic [2:0] FL_LOAD = 3'(BR_FLUSH - 1);

    flush_state_t    r_state;
    flush_state_t    w_state_nxt;
    logic [2:0]      r_fcnt;
    logic [2:0]      w_fcnt_nxt;
    logic [NREG-1:0] w_busy;
    logic            w_rs1_busy;
    logic            w_rs2_busy;
    logic            w_raw;
    logic            w_flushing;
    logic            w_issue;
    logic            w_set_en;

    // Issue is already gated by flushing, so a killed load never marks its rd busy.
    assign w_set_en = w_issue & bus.id_is_load & (bus.id_rd != '0);

    load_scoreboard #(
        .NREG   (NREG),
        .RIDX_W (RIDX_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_set_en),
        .i_set_idx  (bus.id_rd),
        .i_clr_en   (bus.wb_valid),
        .i_clr_idx  (bus.wb_rd),
        .i_rs1      (bus.id_rs1),
        .i_rs2      (bus.id_rs2),
        .o_busy     (w_busy),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy)
    );

    // The branch cycle itself counts toward the flush, so FLUSH lasts BR_FLUSH-1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        if (bus.ex_branch_taken) begin
            if (BR_FLUSH > 1) begin
                w_state_nxt = FLUSH;
                w_fcnt_nxt  = FL_LOAD;
            end else begin
                w_state_nxt = IDLE;
                w_fcnt_nxt  = '0;
            end
        end else if (r_state == FLUSH) begin
            if (r_fcnt <= 3'd1) begin
                w_state_nxt = IDLE;
                w_fcnt_nxt  = '0;
            end else begin
                w_fcnt_nxt  = r_fcnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    assign w_flushing = bus.ex_branch_taken | (r_state == FLUSH);
    assign w_raw      = bus.id_valid & ((bus.id_rs1_used & w_rs1_busy) |
                                        (bus.id_rs2_used & w_rs2_busy));
    assign w_issue    = bus.id_valid & ~w_raw & ~w_flushing;

    // Outputs are held low for the whole time reset is asserted.
    assign bus.flush_id  = rst & w_flushing;
    assign bus.bubble_ex = rst & (w_flushing | w_raw);
    assign bus.stall_if  = rst & w_raw & ~w_flushing;
    assign bus.issue     = rst & w_issue;
    assign bus.busy_vec  = w_busy & {NREG{rst}};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset-mid-flush sequence,
// then random traffic against a register-level reference model.
module tb_hazard_scoreboard;
    localparam int BRF = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(32), .RIDX_W(5)) hif();

    hazard_scoreboard #(.NREG(32), .RIDX_W(5), .BR_FLUSH(BRF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    int nchk = 0;
    int nerr = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       wbv;
        logic [4:0] wbrd;
        logic       st;
        logic       bu;
        logic       fl;
        logic       is;
        logic [31:0] busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, int rs1, logic u1, int rs2, logic u2, int rd, logic ld,
                                logic br, logic wbv, int wbrd, logic st, logic bu, logic fl,
                                logic is, logic [31:0] busy);
        vec_t t;
        t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2; t.rd = 5'(rd);
        t.ld = ld; t.br = br; t.wbv = wbv; t.wbrd = 5'(wbrd);
        t.st = st; t.bu = bu; t.fl = fl; t.is = is; t.busy = busy;
        return t;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic ld, input logic br,
                         input logic wbv, input logic [4:0] wbrd);
        hif.id_valid = v; hif.id_rs1 = rs1; hif.id_rs1_used = u1; hif.id_rs2 = rs2;
        hif.id_rs2_used = u2; hif.id_rd = rd; hif.id_is_load = ld; hif.ex_branch_taken = br;
        hif.wb_valid = wbv; hif.wb_rd = wbrd;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic bu, input logic fl,
                           input logic is, input logic [31:0] busy);
        chk({tag, ".stall_if"},  32'(hif.stall_if),  32'(st));
        chk({tag, ".bubble_ex"}, 32'(hif.bubble_ex), 32'(bu));
        chk({tag, ".flush_id"},  32'(hif.flush_id),  32'(fl));
        chk({tag, ".issue"},     32'(hif.issue),     32'(is));
        chk({tag, ".busy_vec"},  hif.busy_vec,       busy);
    endtask

    // Reference model: a set of outstanding-load registers plus the number of
    // flush cycles still owed after the current one.
    bit mbusy[32];
    int flush_left;

    function automatic bit m_reg_busy(input logic [4:0] r);
        if (r == 0) return 1'b0;
        if (hif.wb_valid && hif.wb_rd == r) return 1'b0;
        return mbusy[r];
    endfunction

    task automatic m_outs(output bit st, output bit bu, output bit fl, output bit is,
                          output logic [31:0] busy);
        bit haz;
        haz = hif.id_valid && ((hif.id_rs1_used && m_reg_busy(hif.id_rs1)) ||
                               (hif.id_rs2_used && m_reg_busy(hif.id_rs2)));
        fl = hif.ex_branch_taken || (flush_left > 0);
        bu = fl || haz;
        st = haz && !fl;
        is = hif.id_valid && !haz && !fl;
        busy = '0;
        for (int r = 0; r < 32; r++) busy[r] = mbusy[r];
    endtask

    task automatic m_step();
        bit st, bu, fl, is;
        logic [31:0] b;
        m_outs(st, bu, fl, is, b);
        if (hif.wb_valid) mbusy[hif.wb_rd] = 1'b0;
        if (is && hif.id_is_load && hif.id_rd != 0) mbusy[hif.id_rd] = 1'b1;
        if (hif.ex_branch_taken) flush_left = BRF - 1;
        else if (flush_left > 0) flush_left--;
    endtask

    initial begin
        // Directed table: each row is one cycle, expected values are those seen before the edge.
        tbl.push_back(mk(1, 0,0, 0,0, 5,1, 0, 0,0,  0,0,0,1, 32'h0));        // 0 load x5
        tbl.push_back(mk(1, 5,1, 0,0, 6,0, 0, 0,0,  1,1,0,0, 32'h20));       // 1 reader of x5
        tbl.push_back(mk(1, 5,1, 0,0, 6,0, 0, 0,0,  1,1,0,0, 32'h20));       // 2
        tbl.push_back(mk(1, 5,1, 0,0, 6,0, 0, 0,0,  1,1,0,0, 32'h20));       // 3
        tbl.push_back(mk(1, 5,1, 0,0, 6,0, 0, 1,5,  0,0,0,1, 32'h20));       // 4 wb x5, issue
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0,0,  0,0,0,0, 32'h0));        // 5
        tbl.push_back(mk(1, 0,0, 0,0, 0,1, 0, 0,0,  0,0,0,1, 32'h0));        // 6 load x0
        tbl.push_back(mk(1, 0,1, 0,1, 4,0, 0, 0,0,  0,0,0,1, 32'h0));        // 7 read x0
        tbl.push_back(mk(1, 0,0, 0,0, 1,0, 1, 0,0,  0,1,1,0, 32'h0));        // 8 branch
        tbl.push_back(mk(1, 0,0, 0,0, 1,0, 0, 0,0,  0,1,1,0, 32'h0));        // 9
        tbl.push_back(mk(1, 0,0, 0,0, 1,0, 0, 0,0,  0,0,0,1, 32'h0));        // 10
        tbl.push_back(mk(1, 0,0, 0,0, 1,0, 1, 0,0,  0,1,1,0, 32'h0));        // 11 branch
        tbl.push_back(mk(1, 0,0, 0,0, 1,0, 1, 0,0,  0,1,1,0, 32'h0));        // 12 second pulse
        tbl.push_back(mk(1, 0,0, 0,0, 1,0, 0, 0,0,  0,1,1,0, 32'h0));        // 13 extended
        tbl.push_back(mk(1, 0,0, 0,0, 1,0, 0, 0,0,  0,0,0,1, 32'h0));        // 14
        tbl.push_back(mk(1, 0,0, 0,0, 3,1, 0, 0,0,  0,0,0,1, 32'h0));        // 15 load x3
        tbl.push_back(mk(1, 3,1, 0,0, 7,1, 1, 0,0,  0,1,1,0, 32'h08));       // 16 load x7 + branch + RAW
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0,0,  0,1,1,0, 32'h08));       // 17
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 1,3,  0,0,0,0, 32'h08));       // 18 wb x3
        tbl.push_back(mk(1, 0,0, 0,0, 9,1, 0, 0,0,  0,0,0,1, 32'h0));        // 19 load x9
        tbl.push_back(mk(1, 0,0, 0,0, 9,1, 0, 1,9,  0,0,0,1, 32'h200));      // 20 set and clear x9
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0,0,  0,0,0,0, 32'h200));      // 21
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 1,9,  0,0,0,0, 32'h200));      // 22 wb x9
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 1,12, 0,0,0,0, 32'h0));        // 23 stray wb
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0,0,  0,0,0,0, 32'h0));        // 24

        // Reset with active inputs: every output must be forced low.
        drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1, 5'd4);
        #12;
        chk_all("reset", 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd,
                  tbl[i].ld, tbl[i].br, tbl[i].wbv, tbl[i].wbrd);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].bu, tbl[i].fl, tbl[i].is, tbl[i].busy);
            @(posedge clk); #1;
        end

        // Reset mid-flush with x5 and x10 outstanding.
        drive(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 5'd10, 1, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk_all("rstseq.br", 0, 1, 1, 0, 32'h420);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("rstseq.flush", 0, 1, 1, 0, 32'h420);
        #2;
        drive(1, 5'd5, 1, 5'd10, 1, 5'd6, 1, 1, 0, 0);
        rst = 1'b0;
        #1;
        chk_all("rstseq.inrst", 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 5'd5, 1, 5'd10, 1, 5'd6, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("rstseq.after", 0, 0, 0, 1, 32'h0);
        @(posedge clk); #1;

        // Random traffic against the reference model.
        for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
        flush_left = 0;
        for (int n = 0; n < 400; n++) begin
            bit st, bu, fl, is;
            logic [31:0] b;
            drive(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), ($urandom % 10) == 0, ($urandom % 3) == 0,
                  5'($urandom_range(0, 7)));
            @(negedge clk);
            m_outs(st, bu, fl, is, b);
            chk_all($sformatf("rnd%0d", n), st, bu, fl, is, b);
            m_step();
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
